// File: rtl/nn_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nn_mac_pkg
//  Brief    : Shared widths, FSM state encoding and sizing helper for the
//             neuron MAC sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package nn_mac_pkg;

    localparam int DATA_W = 18;
    localparam int ACC_W  = 48;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Number of bits needed to count 0..value-1 (0 for value<=1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_mac_sequencer_if
//  Brief    : Control, memory-read and DSP-operand signals of the sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface neuron_mac_sequencer_if
    import nn_mac_pkg::*;
#(
    parameter int ADDR_W = 6
);

    logic                start;
    logic [ACC_W-1:0]    bias;
    logic [ADDR_W-1:0]   idx_addr;
    logic [DATA_W-1:0]   x_rdata;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   mac_a;
    logic [DATA_W-1:0]   mac_b;
    logic [ACC_W-1:0]    mac_c;
    logic [ACC_W-1:0]    mac_p;
    logic                busy;
    logic                out_valid;
    logic [ACC_W-1:0]    sum;

    // Sequencer side
    modport master (
        input  start, bias, x_rdata, w_rdata, mac_p,
        output idx_addr, mac_a, mac_b, mac_c, busy, out_valid, sum
    );

    // Environment side: control, memories, DSP slice and activation stage
    modport slave (
        output start, bias, x_rdata, w_rdata, mac_p,
        input  idx_addr, mac_a, mac_b, mac_c, busy, out_valid, sum
    );

endinterface
`default_nettype wire

// File: rtl/neuron_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_mac_sequencer
//  Brief    : Walks N_INPUTS x/w pairs through an external DSP48 MAC slice and
//             strobes out the 48-bit pre-activation sum.
//  Revision : 1.0 - initial release
// ============================================================================
module neuron_mac_sequencer
    import nn_mac_pkg::*;
#(
    parameter int N_INPUTS    = 64,
    parameter int MAC_LATENCY = 3,
    parameter int ADDR_W      = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    neuron_mac_sequencer_if.master bus
);

    localparam int WCNT_W = (clog2(MAC_LATENCY) > 0) ? clog2(MAC_LATENCY) : 1;
    localparam logic [ADDR_W-1:0] c_IDX_LAST  = ADDR_W'(N_INPUTS - 1);
    localparam logic [WCNT_W-1:0] c_WCNT_LAST = WCNT_W'(MAC_LATENCY - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_idx;
    logic [WCNT_W-1:0]  r_wcnt;
    logic [ACC_W-1:0]   r_acc;
    logic [DATA_W-1:0]  r_mac_a;
    logic [DATA_W-1:0]  r_mac_b;
    logic [ACC_W-1:0]   r_mac_c;
    logic [ACC_W-1:0]   r_sum;
    logic               w_wait_last;
    logic               w_idx_last;

    assign w_wait_last = (r_state == WAIT) && (r_wcnt == c_WCNT_LAST);
    assign w_idx_last  = (r_idx == c_IDX_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = FETCH;
            FETCH:   w_state_nxt = LOAD;
            LOAD:    w_state_nxt = WAIT;
            WAIT:    if (w_wait_last) w_state_nxt = w_idx_last ? DONE : FETCH;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands only move in LOAD, so the product in flight always sees a
    // stable a/b/c and the accumulator feedback through c stays exact.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx   <= '0;
            r_wcnt  <= '0;
            r_acc   <= '0;
            r_mac_a <= '0;
            r_mac_b <= '0;
            r_mac_c <= '0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_acc <= bus.bias;
                        r_idx <= '0;
                    end
                end
                LOAD: begin
                    r_mac_a <= bus.x_rdata;
                    r_mac_b <= bus.w_rdata;
                    r_mac_c <= r_acc;
                    r_wcnt  <= '0;
                end
                WAIT: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (w_wait_last) begin
                        r_acc <= bus.mac_p;
                        // The sum register is loaded on the edge entering DONE.
                        if (w_idx_last) begin
                            r_sum <= bus.mac_p;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.idx_addr  = r_idx;
    assign bus.mac_a     = r_mac_a;
    assign bus.mac_b     = r_mac_b;
    assign bus.mac_c     = r_mac_c;
    assign bus.sum       = r_sum;
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_mac_sequencer
//  Brief    : Bench for neuron_mac_sequencer with memory and DSP slice models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_mac_sequencer;
    import nn_mac_pkg::*;

    localparam int N      = 4;
    localparam int LAT    = 3;
    localparam int AW     = 3;
    localparam int EL     = 2 + LAT;
    localparam int LIMIT  = N * EL + 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic signed [DATA_W-1:0] x_mem [N];
    logic signed [DATA_W-1:0] w_mem [N];

    neuron_mac_sequencer_if #(.ADDR_W(AW)) bus ();

    neuron_mac_sequencer #(
        .N_INPUTS   (N),
        .MAC_LATENCY(LAT),
        .ADDR_W     (AW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clock = ~clock;

    // Input buffer and weight ROM: data valid one cycle after the address.
    always @(posedge clock) begin
        bus.x_rdata <= x_mem[bus.idx_addr[1:0]];
        bus.w_rdata <= w_mem[bus.idx_addr[1:0]];
    end

    // DSP slice: the sequencer's operand registers act as its first stage,
    // followed by LAT-1 internal pipeline registers.
    logic [ACC_W-1:0] p0;
    logic [ACC_W-1:0] p1 = '0;
    logic [ACC_W-1:0] p2 = '0;
    assign p0 = ACC_W'($signed(bus.mac_a) * $signed(bus.mac_b)) + bus.mac_c;
    always @(posedge clock) begin
        p1 <= p0;
        p2 <= p1;
    end
    assign bus.mac_p = p2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [ACC_W-1:0] ref_sum(input logic [ACC_W-1:0] b);
        longint acc;
        acc = longint'($signed(b));
        for (int i = 0; i < N; i++) begin
            acc += longint'(x_mem[i]) * longint'(w_mem[i]);
        end
        return acc[ACC_W-1:0];
    endfunction

    // Called while idle, #1 after an edge; returns in cycle 1 of the run.
    task automatic start_pulse(input logic [ACC_W-1:0] b);
        bus.start = 1'b1;
        bus.bias  = b;
        step();
        bus.start = 1'b0;
        bus.bias  = ACC_W'({$urandom(), $urandom()});
    endtask

    task automatic watch_run(input logic [ACC_W-1:0] exp_sum, input logic [ACC_W-1:0] old_sum,
                             input int poke_at, input bit done_poke);
        int cyc;
        bit seen;
        cyc  = 1;
        seen = 1'b0;
        chk("busy_run", 64'(bus.busy), 64'd1);
        while (cyc <= LIMIT) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            if (((cyc - 1) % EL == 0) && ((cyc - 1) / EL < N))
                chk($sformatf("idx_addr_%0d", (cyc - 1) / EL), 64'(bus.idx_addr), 64'((cyc - 1) / EL));
            if (cyc == 10)
                chk("sum_hold", 64'(bus.sum), 64'(old_sum));
            if (cyc == poke_at) begin
                bus.start = 1'b1;
                bus.bias  = 48'd999;
            end else begin
                bus.start = 1'b0;
            end
            step();
            cyc++;
        end
        bus.start = 1'b0;
        chk("valid_seen", 64'(seen), 64'd1);
        chk("latency", 64'(cyc), 64'(N * EL + 1));
        chk("sum", 64'(bus.sum), 64'(exp_sum));
        if (done_poke) begin
            bus.start = 1'b1;
            bus.bias  = 48'd999;
        end
        step();
        bus.start = 1'b0;
        chk("valid_strobe", 64'(bus.out_valid), 64'd0);
        chk("sum_after", 64'(bus.sum), 64'(exp_sum));
        chk("idle_after", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int ones;
        logic [ACC_W-1:0] b;
        logic [ACC_W-1:0] exp_s;
        logic [ACC_W-1:0] prev;

        bus.start = 1'b0;
        bus.bias  = '0;
        x_mem = '{18'sd1, 18'sd2, 18'sd3, 18'sd4};
        w_mem = '{18'sd5, 18'sd6, 18'sd7, 18'sd8};
        repeat (3) step();
        reset = 1'b0;
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum",   64'(bus.sum), 64'd0);
        chk("rst_idx",   64'(bus.idx_addr), 64'd0);
        chk("rst_mac_a", 64'(bus.mac_a), 64'd0);
        chk("rst_mac_b", 64'(bus.mac_b), 64'd0);
        chk("rst_mac_c", 64'(bus.mac_c), 64'd0);

        // Basic sum
        start_pulse(48'd0);
        watch_run(48'd70, 48'd0, 0, 1'b0);

        // Signed operands with bias
        x_mem = '{-18'sd1, 18'sd2, -18'sd3, 18'sd4};
        w_mem = '{18'sd5, -18'sd6, 18'sd7, 18'sd8};
        start_pulse(48'd100);
        watch_run(48'd94, 48'd70, 0, 1'b0);

        x_mem = '{-18'sd131072, 18'sd0, 18'sd0, 18'sd0};
        w_mem = '{-18'sd131072, 18'sd0, 18'sd0, 18'sd0};
        start_pulse(48'd0);
        watch_run(48'h0004_0000_0000, 48'd94, 0, 1'b0);

        // Wrap-around
        x_mem = '{18'sd1, 18'sd0, 18'sd0, 18'sd0};
        w_mem = '{18'sd1, 18'sd0, 18'sd0, 18'sd0};
        start_pulse(48'h7FFF_FFFF_FFFF);
        watch_run(48'h8000_0000_0000, 48'h0004_0000_0000, 0, 1'b0);

        // Reset during the second WAIT
        x_mem = '{18'sd1, 18'sd2, 18'sd3, 18'sd4};
        w_mem = '{18'sd5, 18'sd6, 18'sd7, 18'sd8};
        start_pulse(48'd0);
        repeat (7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mrst_busy",  64'(bus.busy), 64'd0);
        chk("mrst_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_sum",   64'(bus.sum), 64'd0);
        chk("mrst_mac_a", 64'(bus.mac_a), 64'd0);
        chk("mrst_mac_b", 64'(bus.mac_b), 64'd0);
        chk("mrst_mac_c", 64'(bus.mac_c), 64'd0);
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) ones++;
            step();
        end
        chk("mrst_no_valid", 64'(ones), 64'd0);
        start_pulse(48'd0);
        watch_run(48'd70, 48'd0, 0, 1'b0);

        // Start while busy and in DONE is ignored; next start runs normally
        start_pulse(48'd0);
        watch_run(48'd70, 48'd70, 7, 1'b1);
        start_pulse(48'd0);
        watch_run(48'd70, 48'd70, 0, 1'b0);

        // Back-to-back neurons
        start_pulse(-48'sd70);
        watch_run(48'd0, 48'd70, 0, 1'b0);

        // Randomized neurons
        prev = 48'd0;
        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < N; i++) begin
                x_mem[i] = DATA_W'($urandom());
                w_mem[i] = DATA_W'($urandom());
            end
            b     = ACC_W'({$urandom(), $urandom()});
            exp_s = ref_sum(b);
            start_pulse(b);
            watch_run(exp_s, prev, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 19)) : 0,
                      1'($urandom_range(0, 1)));
            prev = exp_s;
            repeat ($urandom_range(0, 3)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
